// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C master controller:
//   - host command codes written to the command register
//   - controller FSM state encoding
//   - bit positions inside the status word returned on DO when AD=1
//   - calc_qtr(): clocks per quarter SCL bit, rounded up, never below 1
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [7:0] CMD_START  = 8'd1;
    localparam logic [7:0] CMD_STOP   = 8'd2;
    localparam logic [7:0] CMD_RDACK  = 8'd4;
    localparam logic [7:0] CMD_RDNACK = 8'd5;
    localparam logic [7:0] CMD_WRITE  = 8'd6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STOP   = 3'd2,
        BITS   = 3'd3,
        ACKBIT = 3'd4
    } state_t;

    localparam int STAT_DONE  = 0;
    localparam int STAT_ERROR = 1;
    localparam int STAT_BUSY  = 2;

    // ceil(clk_freq / (4 * i2c_freq)), clamped to at least 1.
    function automatic int calc_qtr(input real clk_freq, input real i2c_freq);
        real ratio;
        int  qtr;
        ratio = clk_freq / (4.0 * i2c_freq);
        qtr   = $rtoi(ratio);
        if (real'(qtr) < ratio) qtr = qtr + 1;
        if (qtr < 1) qtr = 1;
        return qtr;
    endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// -----------------------------------------------------------------------------
// i2c_qtr_tick
// Free-running divider that pulses tick for one clock every QTR clocks.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset (counter to 0)
//   restart in  reload the counter so the next tick lands exactly QTR clocks
//               after this edge (used on command accept)
//   tick    out 1 during the last clock of each quarter-bit period
// -----------------------------------------------------------------------------
module i2c_qtr_tick #(
    parameter int QTR = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] LAST = CW'(QTR - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_master_ctrl
// Register-mapped single-master I2C controller. The host loads a byte into
// the data register (AD=0) and then issues one command (AD=1):
// START/RESTART, STOP, WRITE, READ+ACK, READ+NACK. Each bus bit is split
// into four quarters of QTR system clocks.
//
// Optional feature macro: I2C_PAD_EN
//   defined   : SDA pad is driven here (0 or high-Z) and sampled from SDA
//   undefined : SDA stays high-Z, input is taken from SDA_I
//
// Ports:
//   CLK    in     system clock (rising edge)
//   RESET  in     synchronous, active-high reset
//   CS     in     host chip select
//   WE     in     host write enable (write when CS & WE)
//   AD     in     0 = data register, 1 = command/status
//   DI     in  8  host write data
//   DO     out 8  host read data (data register or {5'b0,BUSY,ERROR,DONE})
//   DONE   out    1 = idle / last command complete
//   ERROR  out    1 = last WRITE was NACKed
//   SCL    out    I2C clock, push-pull, idle high
//   SDA    inout  open-drain data pad (driven only with I2C_PAD_EN)
//   SDA_E  out    1 = pull SDA low
//   SDA_O  out    SDA output level (0 when SDA_E=1, else 1)
//   SDA_I  in     SDA level from external pad
// -----------------------------------------------------------------------------
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter real CLK_FREQ = 50.0E6,
    parameter real I2C_FREQ = 400.0E3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS,
    input  logic       WE,
    input  logic       AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       DONE,
    output logic       ERROR,
    output logic       SCL,
    inout  wire        SDA,
    output logic       SDA_E,
    output logic       SDA_O,
    input  logic       SDA_I
);

    localparam int QTR = calc_qtr(CLK_FREQ, I2C_FREQ);

    state_t     state;
    logic [1:0] q;          // current quarter within the bit
    logic [2:0] bit_cnt;    // data bit index within the byte
    logic [7:0] data;       // shared tx/rx shift register
    logic       is_read;
    logic       nack;       // READ ends with NACK instead of ACK
    logic       done;
    logic       error;
    logic       scl;
    logic       sda_e;

    logic       host_wr;
    logic       cmd_valid;
    logic       cmd_accept;
    logic       tick;
    logic       sda_in;
    logic [7:0] status;

    // ------------------------------------------------------------------
    // Pad handling
    // ------------------------------------------------------------------
`ifdef I2C_PAD_EN
    assign SDA    = sda_e ? 1'b0 : 1'bz;
    assign sda_in = SDA;
`else
    assign SDA    = 1'bz;
    assign sda_in = SDA_I;
`endif

    // ------------------------------------------------------------------
    // Host interface
    // ------------------------------------------------------------------
    assign host_wr = CS && WE;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        cmd_valid = 1'b0;
        case (DI)
            CMD_START, CMD_STOP, CMD_RDACK, CMD_RDNACK, CMD_WRITE: cmd_valid = 1'b1;
            default: cmd_valid = 1'b0;
        endcase
    end

    assign cmd_accept = host_wr && AD && done && cmd_valid;

    always_comb begin
        status             = 8'h00;
        status[STAT_DONE]  = done;
        status[STAT_ERROR] = error;
        status[STAT_BUSY]  = ~done;
    end

    assign DO    = AD ? status : data;
    assign DONE  = done;
    assign ERROR = error;
    assign SCL   = scl;
    assign SDA_E = sda_e;
    assign SDA_O = ~sda_e;

    // ------------------------------------------------------------------
    // Quarter-bit timebase, realigned to each accepted command
    // ------------------------------------------------------------------
    i2c_qtr_tick #(.QTR(QTR)) u_qtr_tick (
        .clk     (CLK),
        .reset   (RESET),
        .restart (cmd_accept),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Controller FSM. Bus outputs are registered and only change on the
    // edge that starts a new quarter, so q0 values are loaded on accept.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            q       <= 2'd0;
            bit_cnt <= 3'd0;
            data    <= 8'h00;
            is_read <= 1'b0;
            nack    <= 1'b0;
            done    <= 1'b1;
            error   <= 1'b0;
            scl     <= 1'b1;
            sda_e   <= 1'b0;
        end else begin
            if (host_wr && !AD && done) begin
                data <= DI;
            end

            if (cmd_accept) begin
                done    <= 1'b0;
                error   <= 1'b0;
                q       <= 2'd0;
                bit_cnt <= 3'd0;
                scl     <= 1'b0;
                case (DI)
                    CMD_START: begin
                        state <= START;
                        sda_e <= 1'b0;
                    end
                    CMD_STOP: begin
                        state <= STOP;
                        sda_e <= 1'b1;
                    end
                    CMD_WRITE: begin
                        state   <= BITS;
                        is_read <= 1'b0;
                        sda_e   <= ~data[7];
                    end
                    default: begin  // READ with ACK or NACK
                        state   <= BITS;
                        is_read <= 1'b1;
                        nack    <= (DI == CMD_RDNACK);
                        sda_e   <= 1'b0;
                    end
                endcase
            end else if (tick && state != IDLE) begin
                q <= q + 2'd1;
                case (state)
                    START: begin
                        case (q)
                            2'd0: scl   <= 1'b1;
                            2'd1: sda_e <= 1'b1;   // SDA falls while SCL high
                            2'd2: scl   <= 1'b0;
                            default: begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                    STOP: begin
                        case (q)
                            2'd0: scl   <= 1'b1;
                            2'd1: sda_e <= 1'b0;   // SDA rises while SCL high
                            2'd2: ;
                            default: begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                    BITS: begin
                        case (q)
                            2'd0: scl <= 1'b1;
                            2'd1: ;
                            2'd2: begin
                                scl  <= 1'b0;
                                // Shifting here is safe: sda_e was latched
                                // from data[7] at q0 and holds through q3.
                                data <= {data[6:0], sda_in};
                            end
                            default: begin
                                if (bit_cnt == 3'd7) begin
                                    state <= ACKBIT;
                                    sda_e <= is_read ? ~nack : 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    sda_e   <= is_read ? 1'b0 : ~data[7];
                                end
                            end
                        endcase
                    end
                    ACKBIT: begin
                        case (q)
                            2'd0: scl <= 1'b1;
                            2'd1: ;
                            2'd2: begin
                                scl <= 1'b0;
                                if (!is_read) error <= sda_in;
                            end
                            default: begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_ctrl
// Directed bench for i2c_master_ctrl with CLK_FREQ=4 MHz (QTR=3, so one bit
// is 12 clocks and a byte 108 clocks). SDA_I is held high: every WRITE sees
// a NACK and every READ returns 0xFF.
// -----------------------------------------------------------------------------
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    logic       clk;
    logic       reset;
    logic       cs;
    logic       we;
    logic       ad;
    logic [7:0] di;
    logic [7:0] dout;
    logic       done;
    logic       error;
    logic       scl;
    wire        sda;
    logic       sda_e;
    logic       sda_o;
    logic       sda_i;

    int checks   = 0;
    int failures = 0;

    // Per-cycle bus log of the current command; index 0 is the accept edge.
    logic sda_e_log [0:511];
    logic scl_log   [0:511];
    int   cycles;

    i2c_master_ctrl #(.CLK_FREQ(4.0E6), .I2C_FREQ(400.0E3)) dut (
        .CLK   (clk),
        .RESET (reset),
        .CS    (cs),
        .WE    (we),
        .AD    (ad),
        .DI    (di),
        .DO    (dout),
        .DONE  (done),
        .ERROR (error),
        .SCL   (scl),
        .SDA   (sda),
        .SDA_E (sda_e),
        .SDA_O (sda_o),
        .SDA_I (sda_i)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1;
        we = 1'b1;
        ad = a;
        di = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
    endtask

    // Issue a command and log SCL/SDA_E every clock until DONE returns.
    // inject_at >= 0 fires an extra START command write at that cycle.
    task automatic run_cmd(input logic [7:0] code, input int inject_at, input string tag);
        logic finished;
        host_write(1'b1, code);
        check({tag, "_busy"}, {31'd0, done}, 32'd0);
        check({tag, "_status_busy"}, {24'd0, dout}, 32'h04);
        cycles       = 0;
        finished     = 1'b0;
        sda_e_log[0] = sda_e;
        scl_log[0]   = scl;
        for (int c = 1; c <= 400 && !finished; c++) begin
            if (c - 1 == inject_at) begin
                cs = 1'b1; we = 1'b1; ad = 1'b1; di = CMD_START;
            end
            @(posedge clk);
            #1;
            cs = 1'b0;
            we = 1'b0;
            sda_e_log[c] = sda_e;
            scl_log[c]   = scl;
            if (done) begin
                cycles   = c;
                finished = 1'b1;
            end
        end
        if (!finished) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] bits_e;
        int         rise_at;

        reset = 1'b1;
        cs    = 1'b0;
        we    = 1'b0;
        ad    = 1'b0;
        di    = 8'h00;
        sda_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl",   {31'd0, scl},   32'd1);
        check("rst_sda_e", {31'd0, sda_e}, 32'd0);
        check("rst_sda_o", {31'd0, sda_o}, 32'd1);
        check("rst_done",  {31'd0, done},  32'd1);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_data",  {24'd0, dout},  32'h00);
        ad = 1'b1;
        #1;
        check("rst_status", {24'd0, dout}, 32'h01);
        @(negedge clk);
        reset = 1'b0;

        // START from idle.
        run_cmd(CMD_START, -1, "start");
        check("start_cycles", cycles, 32'd12);
        rise_at = -1;
        for (int c = 1; c <= cycles; c++) begin
            if (rise_at < 0 && sda_e_log[c] && !sda_e_log[c-1]) rise_at = c;
        end
        check("start_sda_rise_cycle", rise_at, 32'd6);
        check("start_scl_at_rise", {31'd0, scl_log[6]}, 32'd1);
        check("start_end_scl",   {31'd0, scl},   32'd0);
        check("start_end_sda_e", {31'd0, sda_e}, 32'd1);

        // WRITE 0xAA -> NACK.
        host_write(1'b0, 8'hAA);
        ad = 1'b0;
        #1;
        check("data_load", {24'd0, dout}, 32'hAA);
        run_cmd(CMD_WRITE, -1, "write");
        check("write_cycles", cycles, 32'd108);
        for (int b = 0; b < 8; b++) bits_e[7-b] = sda_e_log[12*b + 6];
        check("write_bits_sda_e", {24'd0, bits_e}, 32'h55);
        check("write_ack_sda_e", {31'd0, sda_e_log[102]}, 32'd0);
        check("write_ack_scl_high", {31'd0, scl_log[102]}, 32'd1);
        check("write_nack_error", {31'd0, error}, 32'd1);
        ad = 1'b1;
        #1;
        check("write_status", {24'd0, dout}, 32'h03);

        // RESTART, then READ + ACK.
        run_cmd(CMD_START, -1, "restart");
        check("restart_error_cleared", {31'd0, error}, 32'd0);
        check("restart_cycles", cycles, 32'd12);
        run_cmd(CMD_RDACK, -1, "rdack");
        check("rdack_cycles", cycles, 32'd108);
        for (int b = 0; b < 8; b++) bits_e[7-b] = sda_e_log[12*b + 6];
        check("rdack_bits_released", {24'd0, bits_e}, 32'h00);
        check("rdack_ack_sda_e", {31'd0, sda_e_log[102]}, 32'd1);
        check("rdack_error", {31'd0, error}, 32'd0);
        ad = 1'b0;
        #1;
        check("rdack_data", {24'd0, dout}, 32'hFF);

        // READ + NACK.
        run_cmd(CMD_RDNACK, -1, "rdnack");
        check("rdnack_cycles", cycles, 32'd108);
        check("rdnack_ack_sda_e", {31'd0, sda_e_log[102]}, 32'd0);
        ad = 1'b0;
        #1;
        check("rdnack_data", {24'd0, dout}, 32'hFF);

        // STOP with an extra START written mid-phase (must be ignored).
        run_cmd(CMD_STOP, 3, "stop");
        check("stop_cycles", cycles, 32'd12);
        check("stop_end_scl",   {31'd0, scl},   32'd1);
        check("stop_end_sda_e", {31'd0, sda_e}, 32'd0);
        check("stop_end_sda_o", {31'd0, sda_o}, 32'd1);
        check("stop_end_done",  {31'd0, done},  32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("stop_no_late_start", {31'd0, done}, 32'd1);

        // Invalid command code 3 is ignored.
        host_write(1'b1, 8'd3);
        check("invalid_done_now", {31'd0, done}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("invalid_done_later", {31'd0, done}, 32'd1);
        check("invalid_scl", {31'd0, scl}, 32'd1);

        // Reset in the middle of a WRITE releases the bus at once.
        host_write(1'b1, CMD_WRITE);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        ad = 1'b0;
        #1;
        check("midrst_scl",   {31'd0, scl},   32'd1);
        check("midrst_sda_e", {31'd0, sda_e}, 32'd0);
        check("midrst_done",  {31'd0, done},  32'd1);
        check("midrst_data",  {24'd0, dout},  32'h00);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Register-mapped, single-master I2C bus controller.
- Host CPU writes a transmit byte and one command per operation: START/RESTART, STOP, WRITE byte, READ byte with ACK, READ byte with NACK.
- Controller generates SCL/SDA timing from the system clock and reports completion, NACK error and received data.
- Sits on the processor's I/O bus; drives board-level I2C pins.

Parameters:
- CLK_FREQ, 50.0E6, system clock frequency in Hz (real allowed).
- I2C_FREQ, 400.0E3, target SCL frequency in Hz.
- Derived localparam QTR = ceil(CLK_FREQ/(4*I2C_FREQ)), minimum 1: clocks per quarter bit.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CS  in  1  chip select for the host access.
- WE  in  1  write enable; a write occurs when CS&WE are high on a clock edge.
- AD  in  1  address: 0 = data register, 1 = command/status.
- DI  in  8  host write data.
- DO  out  8  host read data: AD=0 gives rx/data register; AD=1 gives {5'b0, BUSY, ERROR, DONE}. Combinational mux on AD.
- DONE  out  1  1 = idle / last command complete.
- ERROR  out  1  1 = last WRITE received NACK.
- SCL  out  1  I2C clock, push-pull, idle high.
- SDA  inout  1  I2C data pad, open-drain (only with macro, see below).
- SDA_E  out  1  pad enable; 1 = pull SDA low.
- SDA_O  out  1  SDA output level; always 0 when SDA_E=1, otherwise 1.
- SDA_I  in  1  SDA input from external pad.

Behaviour:
- Reset values: SCL=1, SDA_E=0, SDA_O=1, DONE=1, ERROR=0, data register=0, state IDLE, quarter counter=0.
- Data write (AD=0, accepted only when DONE=1):
  - Loads DI into the shared data/shift register.
  - Ignored while busy.
- Command write (AD=1, accepted only when DONE=1), DI codes:
  - 1 = START/RESTART
  - 2 = STOP
  - 4 = READ + ACK
  - 5 = READ + NACK
  - 6 = WRITE
  - Other codes ignored.
  - Writes while busy ignored.
- On accept: DONE=0 on the next edge; ERROR cleared on every accepted command.
- Timing: every bus phase lasts QTR clocks; each bit is 4 quarters q0..q3.
- START, 4 quarters (valid from idle or after a byte):
  - q0 SCL=0, SDA released.
  - q1 SCL=1.
  - q2 SDA low.
  - q3 SCL=0.
  - Ends SCL=0, SDA low.
- STOP, 4 quarters:
  - q0 SCL=0, SDA low.
  - q1 SCL=1.
  - q2 SDA released.
  - q3 hold.
  - Ends SCL=1, SDA released.
- Data bit:
  - q0 SCL=0, set SDA.
  - q1, q2 SCL=1; SDA sampled at end of q2.
  - q3 SCL=0.
- WRITE: 8 bits, MSB first, from the shift register; 9th bit SDA released; sampled 1 → ERROR=1.
- READ:
  - SDA released for 8 bits; sampled bits shifted into the data register, MSB first.
  - 9th bit driven low for code 4 (ACK), released for code 5 (NACK).
- Durations:
  - START and STOP: 4*QTR clocks each.
  - Byte: 36*QTR clocks.
  - DONE returns to 1 on the edge that ends the last quarter.
- FSM states: IDLE, START, STOP, BITS, ACKBIT. BUSY = ~DONE.
- No clock stretching, no arbitration.
- RESET mid-operation: immediately returns to reset values; bus released.

Optional Feature:
- Macro I2C_PAD_EN.
- Defined:
  - SDA pad driven internally: 0 when SDA_E=1, else high-Z.
  - Input samples the SDA pin; SDA_I ignored.
- Undefined:
  - SDA permanently high-Z.
  - Input samples SDA_I.
  - SDA_E/SDA_O behave identically in both builds.

Decomposition:
- Package i2c_pkg holds:
  - Command code constants (CMD_START=1, CMD_STOP=2, CMD_RDACK=4, CMD_RDNACK=5, CMD_WRITE=6).
  - FSM state encoding.
  - Status bit positions.
- One sub-module, i2c_qtr_tick:
  - Counter producing a 1-clock tick every QTR clocks.
  - Restarted on command accept.

Test Plan:
- Setup for all scenarios: CLK 20 ns, CLK_FREQ=4.0E6, I2C_FREQ default, so QTR=3; SDA_I held 1.
- Reset → SCL=1, SDA_E=0, DONE=1, ERROR=0, DO(AD=0)=0x00.
- Command 1 → DONE low next clock; SDA_E rises while SCL=1; DONE high after 12 clocks; ends with SCL=0.
- Data 0xAA, then command 6:
  - SDA_E per bit = 0,1,0,1,0,1,0,1.
  - 9th bit SDA_E=0; ERROR=1 (NACK).
  - DONE after 108 clocks.
- Command 1 again (restart), then command 4:
  - DO(AD=0)=0xFF; 9th bit SDA_E=1; ERROR=0.
- Command 5:
  - DO=0xFF; 9th bit SDA_E=0.
- Command 2:
  - Ends SCL=1, SDA_E=0, DONE=1.
  - Extra command write during a busy phase is ignored.
  - Invalid code 3 leaves DONE=1.
